// File: rtl/fp_wire.sv
// Shared fp_unit interface types, plus the register and response types used by
// the fp_unit issue arbiter.
package fp_wire;

    typedef struct packed {
        logic       fmadd;
        logic       fmsub;
        logic       fnmadd;
        logic       fnmsub;
        logic       fadd;
        logic       fsub;
        logic       fmul;
        logic       fdiv;
        logic       fsqrt;
        logic       fsgnj;
        logic       fcmp;
        logic       fmax;
        logic       fclass;
        logic       fmv_i2f;
        logic       fmv_f2i;
        logic       fcvt_i2f;
        logic       fcvt_f2i;
        logic [1:0] fcvt_op;
    } fp_operation_type;

    localparam fp_operation_type init_fp_operation = '0;

    localparam logic [31:0] FP_CANON_NAN = 32'h7FC00000;
    localparam logic [4:0]  FP_FLAG_NV   = 5'b10000;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        RESP
    } fp_arb_state_type;

    typedef struct packed {
        logic [31:0]      data1;
        logic [31:0]      data2;
        logic [31:0]      data3;
        logic [1:0]       fmt;
        logic [2:0]       rm;
        fp_operation_type op;
    } fp_arb_req_type;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  flags;
        logic        error;
    } fp_arb_resp_type;

    // The watchdog count lives beside this register because its width is a
    // parameter of the arbiter instance.
    typedef struct packed {
        fp_arb_state_type state;
        logic             prio;
        logic             id;
        fp_arb_req_type   req;
        fp_arb_resp_type  resp;
    } fp_arb_reg_type;

    localparam fp_arb_reg_type init_fp_arb_reg = '{
        state: IDLE,
        prio:  1'b0,
        id:    1'b0,
        req:   '{data1: '0, data2: '0, data3: '0, fmt: '0, rm: '0, op: init_fp_operation},
        resp:  '{result: '0, flags: '0, error: 1'b0}
    };

endpackage

// File: rtl/fp_issue_arbiter_rr.sv
// Two-input round-robin grant: the prioritised requester wins when valid,
// otherwise the other one.
module fp_issue_arbiter_rr (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant,
    output logic       gid
);

    logic other;

    always_comb begin
        other = ~prio;
        grant = '0;
        gid   = prio;
        if (valid[prio]) begin
            grant[prio] = 1'b1;
            gid         = prio;
        end else if (valid[other]) begin
            grant[other] = 1'b1;
            gid          = other;
        end
    end

endmodule

// File: rtl/fp_issue_arbiter.sv
// Shares one fp_unit port between two requesters: round-robin grant, one op in
// flight, watchdog turns a hung op into an error response.
module fp_issue_arbiter
    import fp_wire::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 10
) (
    input  logic                   reset,
    input  logic                   clock,
    input  logic                   flush,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0][31:0]       req_data1,
    input  logic [1:0][31:0]       req_data2,
    input  logic [1:0][31:0]       req_data3,
    input  logic [1:0][1:0]        req_fmt,
    input  logic [1:0][2:0]        req_rm,
    input  fp_operation_type [1:0] req_op,
    output logic [1:0]             resp_valid,
    input  logic [1:0]             resp_ready,
    output logic [31:0]            resp_result,
    output logic [4:0]             resp_flags,
    output logic                   resp_error,
    output logic [31:0]            fpu_data1,
    output logic [31:0]            fpu_data2,
    output logic [31:0]            fpu_data3,
    output logic [1:0]             fpu_fmt,
    output logic [2:0]             fpu_rm,
    output fp_operation_type       fpu_op,
    output logic                   fpu_enable,
    input  logic [31:0]            fpu_result,
    input  logic [4:0]             fpu_flags,
    input  logic                   fpu_ready
);

    fp_arb_reg_type   r, rin;
    logic [CNT_W-1:0] cnt_r, cnt_rin;
    logic [1:0]       grant;
    logic             gid;

    fp_issue_arbiter_rr u_rr (
        .valid (req_valid),
        .prio  (r.prio),
        .grant (grant),
        .gid   (gid)
    );

    always_comb begin
        req_ready = (r.state == IDLE && !flush) ? grant : '0;
    end

    always_comb begin
        fp_arb_reg_type v;
        logic [CNT_W-1:0] cnt_v;
        v     = r;
        cnt_v = cnt_r;
        case (r.state)
            IDLE: begin
                if (|req_ready) begin
                    v.id        = gid;
                    v.req.data1 = req_data1[gid];
                    v.req.data2 = req_data2[gid];
                    v.req.data3 = req_data3[gid];
                    v.req.fmt   = req_fmt[gid];
                    v.req.rm    = req_rm[gid];
                    v.req.op    = req_op[gid];
                    v.state     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_v   = '0;
                v.state = BUSY;
            end
            BUSY: begin
                // Completion is checked first so it beats a coincident timeout.
                if (fpu_ready) begin
                    v.resp.result = fpu_result;
                    v.resp.flags  = fpu_flags;
                    v.resp.error  = 1'b0;
                    v.state       = RESP;
                end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    v.resp.result = FP_CANON_NAN;
                    v.resp.flags  = FP_FLAG_NV;
                    v.resp.error  = 1'b1;
                    v.state       = RESP;
                end else begin
                    cnt_v = cnt_r + CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready[r.id]) begin
                    v.prio  = ~r.id;
                    v.state = IDLE;
                end
            end
            default: v.state = IDLE;
        endcase
        // An abort leaves the round-robin pointer where it was.
        if (flush && r.state != IDLE) begin
            v.state = IDLE;
            v.prio  = r.prio;
        end
        rin     = v;
        cnt_rin = cnt_v;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r     <= init_fp_arb_reg;
            cnt_r <= '0;
        end else begin
            r     <= rin;
            cnt_r <= cnt_rin;
        end
    end

    always_comb begin
        fpu_enable  = (r.state == ISSUE);
        fpu_data1   = r.req.data1;
        fpu_data2   = r.req.data2;
        fpu_data3   = r.req.data3;
        fpu_fmt     = r.req.fmt;
        fpu_rm      = r.req.rm;
        fpu_op      = r.req.op;
        resp_valid  = (r.state == RESP) ? (r.id ? 2'b10 : 2'b01) : 2'b00;
        resp_result = r.resp.result;
        resp_flags  = r.resp.flags;
        resp_error  = r.resp.error;
    end

endmodule
